// File: rtl/crc16_pkg.sv
// Shared CRC16 definitions for the word generator and the frame checker.
// Polynomial 1+x^5+x^12+x^16, 16-bit parallel update, init 0x0000, no final XOR.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } chk_state_t;

  // One 16-bit word step: next = M * (q ^ d). Sixteen unrolled shift/reduce
  // steps collapse into the fixed XOR matrix at elaboration, so the generator
  // and the checker always agree on one matrix.
  function automatic logic [15:0] crc16_step(input logic [15:0] q, input logic [15:0] d);
    logic [15:0] c;
    c = q ^ d;
    for (int i = 0; i < 16; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ CRC16_POLY) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_frame_checker_if.sv
// Receive stream and verdict/statistics bundle of the CRC16 frame checker.
// master: the side feeding frames and reading verdicts; slave: the checker.
interface crc16_frame_checker_if #(
  parameter int MAX_WORDS = 64,
  parameter int LEN_W     = $clog2(MAX_WORDS + 2),
  parameter int CNT_W     = 16
);

  logic [15:0]      rx_data;
  logic             rx_valid;
  logic             cnt_clr;
  logic             chk_done;
  logic             chk_ok;
  logic             chk_crc_err;
  logic             chk_len_err;
  logic [15:0]      chk_residue;
  logic [LEN_W-1:0] frame_words;
  logic [CNT_W-1:0] ok_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output rx_data, rx_valid, cnt_clr,
    input  chk_done, chk_ok, chk_crc_err, chk_len_err, chk_residue,
           frame_words, ok_cnt, err_cnt
  );

  modport slave (
    input  rx_data, rx_valid, cnt_clr,
    output chk_done, chk_ok, chk_crc_err, chk_len_err, chk_residue,
           frame_words, ok_cnt, err_cnt
  );

endinterface

// File: rtl/crc16_chk_stats.sv
// Saturating pass/fail frame counters for the link-status block.
// Counters advance on the edge that samples the verdict strobe; a clear
// request on that same edge takes priority over the increment.
module crc16_chk_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             done,
  input  logic             ok,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Index 0 counts passing frames, index 1 counts failing frames.
  logic [1:0]            inc;
  logic [1:0][CNT_W-1:0] cnt_q;

  assign inc = {done & ~ok, done & ok};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    // Saturating counter with clear priority over increment.
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (cnt_clr) begin
        cnt_reg <= '0;
      end else if (inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end

    assign cnt_q[gi] = cnt_reg;
  end

  assign ok_cnt  = cnt_q[0];
  assign err_cnt = cnt_q[1];

endmodule

// File: rtl/crc16_frame_checker.sv
// CRC16 receive-side frame checker. Runs the residue over every word of a
// frame (CRC word last); a correct frame leaves a zero residue. At frame end
// it registers a verdict with a one-cycle strobe and feeds the statistics.
module crc16_frame_checker
  import crc16_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int LEN_W     = $clog2(MAX_WORDS + 2),
  parameter int CNT_W     = 16
) (
  input logic                   clk_in,
  input logic                   rst_n,
  crc16_frame_checker_if.slave  bus
);

  localparam logic [LEN_W-1:0] CNT_SAT = LEN_W'(MAX_WORDS + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(2);

  chk_state_t       state_reg;
  logic [LEN_W-1:0] count_reg;
  logic [15:0]      residue_reg;
  logic [15:0]      residue_next;
  logic             len_bad;

  logic             done_reg;
  logic             ok_reg;
  logic             crc_err_reg;
  logic             len_err_reg;
  logic [15:0]      res_out_reg;
  logic [LEN_W-1:0] words_reg;

  // Residue step; a frame's first word always starts from the init value.
  always_comb begin
    residue_next = crc16_step((state_reg == IDLE) ? CRC16_INIT : residue_reg, bus.rx_data);
  end

  // Length window check on the count of the frame that is ending.
  always_comb begin
    len_bad = (count_reg < MIN_LEN) || (count_reg > MAX_LEN);
  end

  // Residue register: advances on valid words, cleared whenever the line is idle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      residue_reg <= CRC16_INIT;
    end else if (bus.rx_valid) begin
      residue_reg <= residue_next;
    end else begin
      residue_reg <= CRC16_INIT;
    end
  end

  // Frame FSM: counts words and captures the verdict on the first idle edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      done_reg    <= 1'b0;
      ok_reg      <= 1'b0;
      crc_err_reg <= 1'b0;
      len_err_reg <= 1'b0;
      res_out_reg <= '0;
      words_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.rx_valid) begin
            state_reg <= RECV;
            count_reg <= LEN_W'(1);
          end
        end
        RECV: begin
          if (bus.rx_valid) begin
            if (count_reg != CNT_SAT) begin
              count_reg <= count_reg + LEN_W'(1);
            end
          end else begin
            state_reg   <= IDLE;
            done_reg    <= 1'b1;
            res_out_reg <= residue_reg;
            crc_err_reg <= (residue_reg != 16'h0000);
            len_err_reg <= len_bad;
            ok_reg      <= (residue_reg == 16'h0000) && !len_bad;
            words_reg   <= count_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.chk_done    = done_reg;
  assign bus.chk_ok      = ok_reg;
  assign bus.chk_crc_err = crc_err_reg;
  assign bus.chk_len_err = len_err_reg;
  assign bus.chk_residue = res_out_reg;
  assign bus.frame_words = words_reg;

  crc16_chk_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .done    (done_reg),
    .ok      (ok_reg),
    .cnt_clr (bus.cnt_clr),
    .ok_cnt  (bus.ok_cnt),
    .err_cnt (bus.err_cnt)
  );

endmodule
